// File: rtl/ccff_stream_shifter.sv
// Serializes configuration words onto the FPGA configuration chain head, bit 0 first.
// Optional macro CCFF_TAIL_CHECK_EN adds a tail loopback check before completion.
module ccff_stream_shifter #(
  parameter int WORD_W        = 32,
  parameter int LEN_W         = 16,
  parameter int PRESET_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              ccff_head_o,
  output logic              progclk_en_o,
  output logic              pReset_o,
  input  logic              ccff_tail_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  bits_sent_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PC_W  = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

`ifdef CCFF_TAIL_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PRESET, S_LOAD, S_SHIFT, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PRESET, S_LOAD, S_SHIFT, S_DONE
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WORD_W-1:0]  shreg_shift;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bits_q, bits_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PC_W-1:0]    pcnt_q, pcnt_d;
  logic               err_q, err_d;
  logic               last_bit;

`ifdef CCFF_TAIL_CHECK_EN
  logic               first_q, first_d;
`else
  logic               unused_tail;
  assign unused_tail = ccff_tail_i;
`endif

  // Right shift by one, zero filling the top bit.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
      assign shreg_shift[gi] = shreg_q[gi+1];
    end
  endgenerate
  assign shreg_shift[WORD_W-1] = 1'b0;

  // Length check wins over word exhaustion so a partial final word ends the load.
  assign last_bit = ((bits_q + LEN_W'(1)) == len_q);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
`ifdef CCFF_TAIL_CHECK_EN
    first_d = first_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = S_PRESET;
            len_d   = len_i;
            bits_d  = '0;
            pcnt_d  = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRESET: begin
        if (pcnt_q == PC_W'(PRESET_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      S_LOAD: begin
        if (word_valid_i) begin
          shreg_d = word_i;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_shift;
        bits_d  = bits_q + LEN_W'(1);
        idx_d   = idx_q + IDX_W'(1);
`ifdef CCFF_TAIL_CHECK_EN
        if (bits_q == '0) begin
          first_d = shreg_q[0];
        end
`endif
        if (last_bit) begin
`ifdef CCFF_TAIL_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (idx_q == IDX_W'(WORD_W - 1)) begin
          state_d = S_LOAD;
        end
      end
`ifdef CCFF_TAIL_CHECK_EN
      S_CHECK: begin
        if (ccff_tail_i == first_q) begin
          state_d = S_DONE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      len_q   <= '0;
      bits_q  <= '0;
      idx_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
`ifdef CCFF_TAIL_CHECK_EN
      first_q <= first_d;
`endif
    end
  end

  // All outputs decode registered state, so nothing combinational reaches them from inputs.
  assign word_ready_o = (state_q == S_LOAD);
  assign progclk_en_o = (state_q == S_SHIFT);
  assign ccff_head_o  = (state_q == S_SHIFT) & shreg_q[0];
  assign pReset_o     = (state_q == S_PRESET);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign bits_sent_o  = bits_q;

endmodule

// File: tb/tb_ccff_stream_shifter.sv
// Scoreboard bench for ccff_stream_shifter: the driver queues expected chain bits,
// a negedge monitor pops and compares on every programming-clock enable.
module tb_ccff_stream_shifter;

  localparam int PC = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o, ccff_head_o, progclk_en_o, pReset_o;
  logic        ccff_tail_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] bits_sent_o;

  int   chain_len = 32;
  logic tail_inv = 1'b0;

  always #5 clk = ~clk;

`ifdef CCFF_TAIL_CHECK_EN
  logic [4095:0] chain = '0;
  always @(posedge clk) if (progclk_en_o) chain <= {chain[4094:0], ccff_head_o};
  assign ccff_tail_i = chain[chain_len-1] ^ tail_inv;
`else
  assign ccff_tail_i = 1'b0;
`endif

  ccff_stream_shifter dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .ccff_head_o(ccff_head_o), .progclk_en_o(progclk_en_o), .pReset_o(pReset_o),
    .ccff_tail_i(ccff_tail_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .bits_sent_o(bits_sent_o)
  );

  int checks = 0;
  int passes = 0;
  bit sb[$];
  bit exp_bit;
  int pulse_cnt = 0, done_cnt = 0, preset_cnt = 0, overlap_cnt = 0;
  int gap_cnt = 0, gap_max = 0, cyc = 0, last_pulse = 0;

  // Monitor: compare every programming-clock bit against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (progclk_en_o) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL extra_bit: pulse %0d head=%0b, required no pulse", pulse_cnt, ccff_head_o);
      end else begin
        exp_bit = sb.pop_front();
        if (ccff_head_o !== exp_bit)
          $display("FAIL head_bit[%0d]: got %0b required %0b", pulse_cnt, ccff_head_o, exp_bit);
        else
          passes++;
      end
      if (pulse_cnt > 0 && (cyc - last_pulse) > 1) begin
        gap_cnt++;
        if (cyc - last_pulse - 1 > gap_max) gap_max = cyc - last_pulse - 1;
      end
      last_pulse = cyc;
      pulse_cnt++;
    end
    if (done_o) done_cnt++;
    if (pReset_o) preset_cnt++;
    if (pReset_o && progclk_en_o) overlap_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    else passes++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"},  word_ready_o, 0);
    chk({tag, "_head"},   ccff_head_o, 0);
    chk({tag, "_progen"}, progclk_en_o, 0);
    chk({tag, "_preset"}, pReset_o, 0);
    chk({tag, "_busy"},   busy_o, 0);
    chk({tag, "_done"},   done_o, 0);
    chk({tag, "_err"},    err_o, 0);
    chk({tag, "_bits"},   bits_sent_o, 0);
  endtask

  task automatic run_load(input int len, input logic [31:0] w, input int gap,
                          input int abort_bits, input bit mid_start, output int hs);
    int nwords, pushed, low_cnt, nb, t;
    bit did_mid;
    nwords = (len + 31) / 32;
    chain_len = len;
    pulse_cnt = 0; done_cnt = 0; preset_cnt = 0; overlap_cnt = 0;
    gap_cnt = 0; gap_max = 0;
    sb.delete();
    start_i = 1'b1;
    len_i = 16'(len);
    step();
    start_i = 1'b0;
    len_i = '0;
    chk("preset_first", pReset_o, 1);
    chk("busy_after_start", busy_o, 1);
    chk("err_cleared", err_o, 0);
    chk("bits_cleared", bits_sent_o, 0);
    for (int i = 2; i <= PC; i++) begin
      step();
      chk("preset_hold", pReset_o, 1);
      chk("ready_low_in_preset", word_ready_o, 0);
    end
    step();
    chk("ready_after_preset", word_ready_o, 1);
    chk("preset_released", pReset_o, 0);
    hs = 0; pushed = 0; low_cnt = 0; did_mid = 0;
    word_i = w;
    for (t = 0; t < 20000; t++) begin
      if (abort_bits > 0 && pulse_cnt >= abort_bits) begin
        word_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sb.delete();
        check_reset_outs("abort");
        return;
      end
      if (mid_start && !did_mid && pulse_cnt == 40) begin
        start_i = 1'b1;
        len_i = 16'd5;
        did_mid = 1'b1;
      end else begin
        start_i = 1'b0;
        len_i = '0;
      end
      if (word_ready_o && hs < nwords) begin
        if (gap == 0 || hs == 0 || low_cnt >= gap - 1) begin
          word_valid_i = 1'b1;
          nb = (len - pushed < 32) ? (len - pushed) : 32;
          for (int b = 0; b < nb; b++) sb.push_back(w[b]);
          pushed += nb;
          hs++;
          low_cnt = 0;
        end else begin
          word_valid_i = 1'b0;
          low_cnt++;
        end
      end else begin
        word_valid_i = (gap == 0 && hs < nwords);
      end
      if (hs == nwords && !busy_o) break;
      step();
    end
    start_i = 1'b0;
    word_valid_i = 1'b0;
    if (t >= 20000) begin
      checks++;
      $display("FAIL load_timeout: got %0d cycles without completion, required fewer", t);
    end
    step();
    step();
  endtask

  task automatic finish_checks(input string tag, input int len, input int hs,
                               input int exp_done, input int exp_err);
    chk({tag, "_handshakes"}, hs, (len + 31) / 32);
    chk({tag, "_pulses"}, pulse_cnt, len);
    chk({tag, "_done_count"}, done_cnt, exp_done);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_bits_sent"}, bits_sent_o, len);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_busy_idle"}, busy_o, 0);
    chk({tag, "_overlap"}, overlap_cnt, 0);
    chk({tag, "_preset_cycles"}, preset_cnt, PC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    #1;
    repeat (3) step();
    check_reset_outs("in_reset");
    rst_i = 1'b0;
    step();
    check_reset_outs("post_reset");

    // 548 bits, valid always high: 18 words, one-cycle LOAD bubble between words
    run_load(548, 32'h89abcdef, 0, 0, 0, hs);
    finish_checks("len548", 548, hs, 1, 0);
    chk("len548_gap_count", gap_cnt, 17);
    chk("len548_gap_max", gap_max, 1);

    // 64 bits with the source stalling: 10-cycle hole in the programming clock
    run_load(64, 32'ha5c30f96, 10, 0, 0, hs);
    finish_checks("len64_gap", 64, hs, 1, 0);
    chk("len64_gap_count", gap_cnt, 1);
    chk("len64_gap_max", gap_max, 10);

    // Zero length is rejected in IDLE
    preset_cnt = 0;
    start_i = 1'b1;
    len_i = '0;
    step();
    start_i = 1'b0;
    chk("len0_err", err_o, 1);
    chk("len0_busy", busy_o, 0);
    repeat (3) step();
    chk("len0_no_preset", preset_cnt, 0);
    chk("len0_err_sticky", err_o, 1);
    run_load(32, 32'h00001234, 0, 0, 0, hs);
    finish_checks("len32_after_err", 32, hs, 1, 0);

    // Reset during bit 300 of a 936-bit load, then a clean run
    run_load(936, 32'h13579bdf, 0, 300, 0, hs);
    step();
    check_reset_outs("abort_settled");
    run_load(96, 32'hdeadbeef, 0, 0, 0, hs);
    finish_checks("len96_after_rst", 96, hs, 1, 0);

    // start_i during SHIFT must not disturb length or count
    run_load(96, 32'h0f0f3c3c, 0, 0, 1, hs);
    finish_checks("mid_start", 96, hs, 1, 0);

    // Single-word chain with bit 0 set
    run_load(32, 32'h00000001, 0, 0, 0, hs);
    finish_checks("len32_one", 32, hs, 1, 0);

`ifdef CCFF_TAIL_CHECK_EN
    tail_inv = 1'b1;
    run_load(32, 32'h00000001, 0, 0, 0, hs);
    finish_checks("tail_mismatch", 32, hs, 0, 1);
    tail_inv = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
